// File: rtl/ext_rom_pkg.sv
// Shared types and constants for the external code-ROM fetch interface.
package ext_rom_pkg;

  localparam int ADDR_W = 16;
  localparam logic [7:0] ROM_TIMEOUT_DATA = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    READY = 2'd2
  } rom_state_e;

endpackage

// File: rtl/ext_rom_pfbuf.sv
// One-entry prefetch buffer: holds {tag, data, valid} and compares a lookup address.
module ext_rom_pfbuf
  import ext_rom_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_inv,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_wr_tag,
  input  logic [7:0]        i_wr_data,
  input  logic [ADDR_W-1:0] i_lookup,
  output logic              o_hit,
  output logic [7:0]        o_data
);

  logic [ADDR_W-1:0] r_tag;
  logic [7:0]        r_data;
  logic              r_valid;

  // Invalidate wins over a same-cycle write so an aborted prefetch never lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_inv) begin
      r_valid <= 1'b0;
    end else if (i_wr) begin
      r_tag   <= i_wr_tag;
      r_data  <= i_wr_data;
      r_valid <= 1'b1;
    end
  end

  assign o_hit  = r_valid && (r_tag == i_lookup);
  assign o_data = r_data;

endmodule

// File: rtl/ext_rom_if.sv
// MCU external code-fetch bridge: ALE/PSEN bus to a req/ack code memory.
// Optional one-entry next-address prefetch is enabled with EXT_ROM_PREFETCH_EN.
module ext_rom_if
  import ext_rom_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ALE,
  input  logic              PSEN,
  input  logic [7:0]        P0_in,
  input  logic [7:0]        P2_in,
  output logic [7:0]        P0_out,
  output logic              P0_oe,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              busy,
  output logic              err,
  output logic [1:0]        o_dbg_state
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  rom_state_e        r_state;
  logic              r_ale_d;
  logic              r_psen_d;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic [7:0]        r_cnt;
  logic              r_err;

  logic              w_ale_fall;
  logic              w_psen_rise;
  logic              w_timeout;
  logic [ADDR_W-1:0] w_pin_addr;

  assign w_ale_fall  = r_ale_d && !ALE;
  assign w_psen_rise = !r_psen_d && PSEN;
  assign w_timeout   = (r_cnt == TO_LAST);
  assign w_pin_addr  = {P2_in, P0_in};

`ifdef EXT_ROM_PREFETCH_EN
  logic              r_pf_active;
  logic [ADDR_W-1:0] r_pf_addr;
  logic              w_buf_hit;
  logic              w_pf_hit;
  logic [7:0]        w_buf_data;

  // A hit only counts when no prefetch is in flight; an ALE during one always invalidates.
  assign w_pf_hit = w_buf_hit && !r_pf_active;

  ext_rom_pfbuf u_pfbuf (
    .clk       (clk),
    .reset     (reset),
    .i_inv     (w_ale_fall && !w_pf_hit),
    .i_wr      (r_pf_active && mem_ack && !w_ale_fall),
    .i_wr_tag  (r_pf_addr),
    .i_wr_data (mem_data),
    .i_lookup  (w_pin_addr),
    .o_hit     (w_buf_hit),
    .o_data    (w_buf_data)
  );

  assign mem_req  = (r_state == REQ) || r_pf_active;
  assign mem_addr = r_pf_active ? r_pf_addr : r_addr;
`else
  assign mem_req  = (r_state == REQ);
  assign mem_addr = r_addr;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_ale_d  <= 1'b0;
      r_psen_d <= 1'b1;
      r_addr   <= '0;
      r_data   <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
`ifdef EXT_ROM_PREFETCH_EN
      r_pf_active <= 1'b0;
      r_pf_addr   <= '0;
`endif
    end else begin
      r_ale_d  <= ALE;
      r_psen_d <= PSEN;
      // A new address always aborts whatever is in progress, including a same-cycle ack.
      if (w_ale_fall) begin
        r_addr <= w_pin_addr;
        r_cnt  <= '0;
`ifdef EXT_ROM_PREFETCH_EN
        r_pf_active <= 1'b0;
        if (w_pf_hit) begin
          r_data  <= w_buf_data;
          r_state <= READY;
        end else begin
          r_state <= REQ;
        end
`else
        r_state <= REQ;
`endif
      end else begin
        case (r_state)
          REQ: begin
            if (mem_ack) begin
              r_data  <= mem_data;
              r_state <= READY;
`ifdef EXT_ROM_PREFETCH_EN
              r_pf_active <= 1'b1;
              r_pf_addr   <= r_addr + 16'd1;
              r_cnt       <= '0;
`endif
            end else if (w_timeout) begin
              r_data  <= ROM_TIMEOUT_DATA;
              r_err   <= 1'b1;
              r_state <= READY;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          READY: begin
            if (w_psen_rise) r_state <= IDLE;
          end
          default: r_state <= r_state;
        endcase
`ifdef EXT_ROM_PREFETCH_EN
        // Prefetch completion or silent timeout; a prefetch timeout never sets err.
        if (r_pf_active) begin
          if (mem_ack || w_timeout) r_pf_active <= 1'b0;
          else                      r_cnt       <= r_cnt + 8'd1;
        end
`endif
      end
    end
  end

  assign busy        = (r_state != IDLE);
  assign err         = r_err;
  assign P0_oe       = (r_state == READY) && !PSEN;
  assign P0_out      = P0_oe ? r_data : 8'h00;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ext_rom_if.sv
// Directed plus randomized bench for ext_rom_if; prefetch steps run when EXT_ROM_PREFETCH_EN is defined.
module tb_ext_rom_if;
  import ext_rom_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ALE, PSEN, mem_ack;
  logic [7:0]  P0_in, P2_in, mem_data;
  logic [7:0]  P0_out;
  logic        P0_oe, mem_req, busy, err;
  logic [15:0] mem_addr;
  logic [1:0]  dbg_state;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[$];
  logic        exp_err = 1'b0;

  always #5 clk = ~clk;

  ext_rom_if #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .ALE         (ALE),
    .PSEN        (PSEN),
    .P0_in       (P0_in),
    .P2_in       (P2_in),
    .P0_out      (P0_out),
    .P0_oe       (P0_oe),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .busy        (busy),
    .err         (err),
    .o_dbg_state (dbg_state)
  );

  // Outputs are observed 1 time unit after the rising edge, never on it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic ale_fall(input logic [15:0] a);
    ALE = 1'b1;
    tick();
    ALE   = 1'b0;
    P2_in = a[15:8];
    P0_in = a[7:0];
    tick();
    P2_in = 8'($urandom);
    P0_in = 8'($urandom);
  endtask

  // Answers the request on its ack_at-th cycle (counting from 0); returns cycles mem_req was seen high.
  task automatic serve(input int ack_at, input logic [7:0] d, output int n_req);
    n_req = 0;
    for (int k = 0; k < TO + 3; k++) begin
      if (!mem_req) break;
      n_req++;
      mem_ack  = (k == ack_at);
      mem_data = d;
      tick();
    end
    mem_ack  = 1'b0;
    mem_data = 8'($urandom);
  endtask

  task automatic read_out();
    check("busy_ready", 32'(busy), 32'd1);
    check("oe_psen_hi", 32'(P0_oe), 32'd0);
    check("out_psen_hi", 32'(P0_out), 32'h00);
    PSEN = 1'b0;
    #1;
    check("oe_psen_lo", 32'(P0_oe), 32'd1);
    check("out_byte", 32'(P0_out), 32'(exp_q.pop_front()));
    check("err_flag", 32'(err), 32'(exp_err));
    tick();
    PSEN = 1'b1;
    tick();
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  // Reference: an ack inside the TO-cycle window delivers data, otherwise 0xFF and sticky err.
  task automatic run_fetch(input logic [15:0] a, input int ack_at, input logic [7:0] d);
    int n_req;
    exp_q.push_back((ack_at < TO) ? d : 8'hFF);
    if (ack_at >= TO) exp_err = 1'b1;
    ale_fall(a);
    check("req_addr", 32'(mem_addr), 32'(a));
    serve(ack_at, d, n_req);
    check("req_cycles", 32'(n_req), 32'((ack_at < TO) ? ack_at + 1 : TO));
    read_out();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_req;
    reset = 1'b0; ALE = 1'b0; PSEN = 1'b1; mem_ack = 1'b0;
    P0_in = 8'h00; P2_in = 8'h00; mem_data = 8'h00;
    tick();
    tick();
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'h0000);
    check("rst_out", 32'(P0_out), 32'h00);
    #2 reset = 1'b1;
    tick();

`ifdef EXT_ROM_PREFETCH_EN
    ale_fall(16'hFFFF);
    mem_ack = 1'b1; mem_data = 8'h11;
    tick();
    mem_ack = 1'b0;
    check("pf_state_ready", 32'(dbg_state), 32'(READY));
    check("pf_req_on", 32'(mem_req), 32'd1);
    check("pf_wrap_addr", 32'(mem_addr), 32'h0000);
    mem_ack = 1'b1; mem_data = 8'h22;
    tick();
    mem_ack = 1'b0;
    check("pf_req_done", 32'(mem_req), 32'd0);
    PSEN = 1'b0; #1;
    check("pf_first_byte", 32'(P0_out), 32'h11);
    tick(); PSEN = 1'b1; tick();
    ale_fall(16'h0000);
    check("pf_hit_ready", 32'(dbg_state), 32'(READY));
    check("pf_hit_noreq", 32'(mem_req), 32'd0);
    PSEN = 1'b0; #1;
    check("pf_hit_byte", 32'(P0_out), 32'h22);
    tick(); PSEN = 1'b1; tick();
    ale_fall(16'h0005);
    check("pf_miss_state", 32'(dbg_state), 32'(REQ));
    check("pf_miss_req", 32'(mem_req), 32'd1);
    check("pf_miss_addr", 32'(mem_addr), 32'h0005);
`else
    // Ack in IDLE must be ignored.
    mem_ack = 1'b1; mem_data = 8'h33;
    tick();
    mem_ack = 1'b0;
    check("stray_ack_busy", 32'(busy), 32'd0);
    check("stray_ack_req", 32'(mem_req), 32'd0);

    // Basic fetch; ack on the last cycle before timeout still wins.
    run_fetch(16'h1234, 3, 8'hA5);

    // Timeout: no ack at all.
    run_fetch(16'h0BAD, TO + 5, 8'h5A);

    for (int i = 0; i < 12; i++) begin
      run_fetch(16'($urandom), int'($urandom_range(0, TO + 1)), 8'($urandom));
    end

    // Abort with a late ack for the old address in the same cycle.
    ale_fall(16'h0020);
    tick();
    ALE = 1'b1;
    tick();
    ALE = 1'b0; P2_in = 8'h00; P0_in = 8'h40;
    mem_ack = 1'b1; mem_data = 8'h77;
    tick();
    mem_ack = 1'b0;
    check("abort_addr", 32'(mem_addr), 32'h0040);
    check("abort_req", 32'(mem_req), 32'd1);
    serve(TO + 5, 8'h00, n_req);
    check("abort_restart", 32'(n_req), 32'(TO));
    exp_q.push_back(8'hFF);
    exp_err = 1'b1;
    read_out();

    // Asynchronous reset between edges while requesting.
    ale_fall(16'h1357);
    #2 reset = 1'b0;
    #1;
    check("arst_req", 32'(mem_req), 32'd0);
    check("arst_oe", 32'(P0_oe), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_addr", 32'(mem_addr), 32'h0000);
    #3 reset = 1'b1;
    exp_err = 1'b0;
    tick();
    run_fetch(16'hC0DE, 1, 8'h3C);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
